// File: rtl/cpp_internal_int_to_double_serial.sv
// Serial int32 -> IEEE-754 double converter using toggle-event handshakes.
// Normalization shifts one bit per clock, so latency depends on leading zeros.
module cpp_internal_int_to_double_serial #(
   parameter int EXP_BIAS = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] in,
   input  logic        update_in,
   output logic [63:0] out,
   output logic        update_out,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, NORM, PACK} state_t;

   state_t      state;
   logic        upd_d;
   logic        pending;
   logic        sgn;
   logic        zero;
   logic [31:0] mag;
   logic [4:0]  e;
   logic        evt;
   logic [10:0] exp_field;

   assign evt       = update_in ^ upd_d;
   assign exp_field = 11'(EXP_BIAS) + 11'(e);

   // upd_d tracks update_in even during reset so a toggle coinciding with
   // reset is swallowed instead of surfacing as an event afterwards.
   always_ff @(posedge clk) begin
      upd_d <= update_in;
      if (rst) begin
         state      <= IDLE;
         out        <= '0;
         update_out <= 1'b0;
         busy       <= 1'b0;
         pending    <= 1'b0;
         sgn        <= 1'b0;
         zero       <= 1'b0;
         mag        <= '0;
         e          <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (evt || pending) begin
                  sgn     <= in[31];
                  mag     <= in[31] ? (~in + 32'd1) : in;
                  e       <= 5'd31;
                  pending <= 1'b0;
                  zero    <= (in == 32'd0);
                  busy    <= 1'b1;
                  state   <= (in == 32'd0) ? PACK : NORM;
               end
            end
            NORM: begin
               if (evt)
                  pending <= 1'b1;
               if (mag[31])
                  state <= PACK;
               else begin
                  mag <= mag << 1;
                  e   <= e - 5'd1;
               end
            end
            PACK: begin
               // Events here are deferred to the next IDLE edge via pending.
               if (evt)
                  pending <= 1'b1;
               out        <= zero ? 64'h0 : {sgn, exp_field, mag[30:0], 21'b0};
               update_out <= ~update_out;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
